// File: rtl/ram_read_bridge.sv
// rtl/ram_read_bridge.sv - Avalon-MM read-only slave bridging Nios II reads to the sample RAM conduit
//
// Reads from the external waveform/sample RAM through a conduit, plus a small
// status space selected by the address MSB.
//
// Ports:
//   csi_clk          system clock
//   csi_reset_n      asynchronous active-low reset
//   avs_chipselect   Avalon slave select
//   avs_address      MSB=0 RAM word address, MSB=1 status offset
//   avs_read         Avalon read strobe
//   avs_readdata     registered read result, held between transfers
//   avs_waitrequest  stall; low for exactly one cycle when the result is ready
//   coe_RD_ADDR      registered RAM read address
//   coe_RD_EN        one-cycle RAM read enable pulse
//   coe_RD_DATA      RAM read data, valid RD_LATENCY edges after the launch edge
module ram_read_bridge #(
    parameter int RAM_WIDTH  = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                 csi_clk,
    input  logic                 csi_reset_n,
    input  logic                 avs_chipselect,
    input  logic [RAM_WIDTH:0]   avs_address,
    input  logic                 avs_read,
    output logic [31:0]          avs_readdata,
    output logic                 avs_waitrequest,
    output logic [RAM_WIDTH-1:0] coe_RD_ADDR,
    output logic                 coe_RD_EN,
    input  logic [RAM_WIDTH-1:0] coe_RD_DATA
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT = RD_LATENCY[2:0];

    state_t      state;
    logic [2:0]  cnt;
    logic [15:0] rd_count;
    logic [31:0] status_word;

    // The only cycle the master is released is DONE; everything else stalls.
    assign avs_waitrequest = avs_chipselect & avs_read & (state != DONE);

    always_comb begin
        status_word = 32'd0;
        if (avs_address[RAM_WIDTH-1:0] == RAM_WIDTH'(0)) begin
            status_word = {16'd0, rd_count};
        end else if (avs_address[RAM_WIDTH-1:0] == RAM_WIDTH'(1)) begin
            status_word = {29'd0, LAT};
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            rd_count     <= 16'd0;
            avs_readdata <= 32'd0;
            coe_RD_ADDR  <= '0;
            coe_RD_EN    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    coe_RD_EN <= 1'b0;
                    if (avs_chipselect && avs_read) begin
                        if (!avs_address[RAM_WIDTH]) begin
                            coe_RD_ADDR <= avs_address[RAM_WIDTH-1:0];
                            coe_RD_EN   <= 1'b1;
                            cnt         <= LAT;
                            state       <= WAIT;
                        end else begin
                            avs_readdata <= status_word;
                            state        <= DONE;
                        end
                    end
                end
                WAIT: begin
                    // The RAM access always finishes, even if the master has
                    // withdrawn, so rd_count tracks every access actually issued.
                    coe_RD_EN <= 1'b0;
                    cnt       <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        avs_readdata <= {{(32-RAM_WIDTH){1'b0}}, coe_RD_DATA};
                        if (rd_count != 16'hFFFF) begin
                            rd_count <= rd_count + 16'd1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    coe_RD_EN <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    coe_RD_EN <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_read_bridge.sv
// tb/tb_ram_read_bridge.sv - scoreboard bench for ram_read_bridge
module tb_ram_read_bridge;

    logic        csi_clk = 1'b0;
    logic        csi_reset_n;
    logic        avs_chipselect;
    logic [12:0] avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [11:0] coe_RD_ADDR;
    logic        coe_RD_EN;
    logic [11:0] coe_RD_DATA;

    ram_read_bridge #(.RAM_WIDTH(12), .RD_LATENCY(2)) dut (
        .csi_clk        (csi_clk),
        .csi_reset_n    (csi_reset_n),
        .avs_chipselect (avs_chipselect),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .coe_RD_ADDR    (coe_RD_ADDR),
        .coe_RD_EN      (coe_RD_EN),
        .coe_RD_DATA    (coe_RD_DATA)
    );

    always #5 csi_clk = ~csi_clk;

    typedef struct {
        logic [31:0] data;
        int          waits;
        int          ens;
        logic [11:0] addr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   total_en = 0;
    int   w_cnt = 0;
    int   en_cnt = 0;

    // RAM model: registers the addressed word on the edge that sees RD_EN,
    // so data is stable for the bridge's capture one edge later.
    function automatic logic [11:0] mem(input logic [11:0] a);
        if (a == 12'h005) return 12'hABC;
        return 12'(a * 12'd37 + 12'd11);
    endfunction

    always @(posedge csi_clk) begin
        if (coe_RD_EN) coe_RD_DATA <= mem(coe_RD_ADDR);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard when the DUT releases the master.
    always @(negedge csi_clk) begin
        exp_t e;
        if (coe_RD_EN) total_en++;
        if (csi_reset_n && avs_chipselect && avs_read) begin
            if (coe_RD_EN) begin
                en_cnt++;
                if (q.size() > 0) check("rd_addr", 32'(coe_RD_ADDR), 32'(q[0].addr));
            end
            if (avs_waitrequest) begin
                w_cnt++;
            end else begin
                if (q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("readdata", avs_readdata, e.data);
                    check("wait_cycles", 32'(w_cnt), 32'(e.waits));
                    check("rd_en_pulses", 32'(en_cnt), 32'(e.ens));
                end
                w_cnt = 0;
                en_cnt = 0;
            end
        end else begin
            w_cnt = 0;
            en_cnt = 0;
        end
    end

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic do_read(input logic [12:0] a, input logic [31:0] exp, input bit ram);
        exp_t e;
        e.data  = exp;
        e.waits = ram ? 3 : 1;
        e.ens   = ram ? 1 : 0;
        e.addr  = a[11:0];
        q.push_back(e);
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge csi_clk);
            if (!avs_waitrequest) break;
        end
        check("timeout", 32'(avs_waitrequest), 32'd0);
        @(posedge csi_clk);
        #1;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
    endtask

    task automatic pulse_reset();
        csi_reset_n = 1'b0;
        #2;
        csi_reset_n = 1'b1;
        @(posedge csi_clk);
        #1;
    endtask

    int e0;

    initial begin
        csi_reset_n    = 1'b0;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_address    = '0;
        coe_RD_DATA    = '0;
        repeat (3) @(negedge csi_clk);
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_rd_addr", 32'(coe_RD_ADDR), 32'd0);
        check("rst_rd_en", 32'(coe_RD_EN), 32'd0);
        check("rst_waitreq", 32'(avs_waitrequest), 32'd0);
        @(posedge csi_clk);
        #1;
        csi_reset_n = 1'b1;
        @(posedge csi_clk);
        #1;

        // T1
        do_read(13'h0005, 32'h0000_0ABC, 1'b1);
        pulse_reset();

        // T2
        do_read(13'h0000, 32'h0000_000B, 1'b1);
        do_read(13'h0FFF, 32'h0000_0FE6, 1'b1);
        do_read(13'h0123, 32'h0000_0A1A, 1'b1);
        do_read(13'h1000, 32'd3, 1'b0);

        // T3
        e0 = total_en;
        do_read(13'h1001, 32'd2, 1'b0);
        do_read(13'h1007, 32'd0, 1'b0);
        do_read(13'h1000, 32'd3, 1'b0);
        check("status_no_rd_en", 32'(total_en - e0), 32'd0);

        // T4
        @(negedge csi_clk);
        force dut.rd_count = 16'hFFFE;
        #1;
        release dut.rd_count;
        @(posedge csi_clk);
        #1;
        do_read(13'h1000, 32'h0000_FFFE, 1'b0);
        for (int i = 0; i < 3; i++) do_read(13'h0005, 32'h0000_0ABC, 1'b1);
        do_read(13'h1000, 32'h0000_FFFF, 1'b0);

        // T5
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = 13'h00AA;
        @(negedge csi_clk);
        @(negedge csi_clk);
        check("t5_rd_en_before", 32'(coe_RD_EN), 32'd1);
        #1;
        csi_reset_n = 1'b0;
        #1;
        check("t5_rd_en_async", 32'(coe_RD_EN), 32'd0);
        check("t5_readdata", avs_readdata, 32'd0);
        check("t5_state", 32'(dut.state), 32'd0);
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        @(posedge csi_clk);
        #1;
        csi_reset_n = 1'b1;
        @(posedge csi_clk);
        #1;
        do_read(13'h1000, 32'd0, 1'b0);
        do_read(13'h00AA, 32'h0000_089D, 1'b1);
        do_read(13'h1000, 32'd1, 1'b0);

        // T6
        e0 = total_en;
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = 13'h00F0;
        @(posedge csi_clk);
        #1;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        repeat (3) @(posedge csi_clk);
        #1;
        check("t6_single_rd_en", 32'(total_en - e0), 32'd1);
        check("t6_captured", avs_readdata, 32'h0000_02BB);
        do_read(13'h1000, 32'd2, 1'b0);
        do_read(13'h00F0, 32'h0000_02BB, 1'b1);
        do_read(13'h1000, 32'd3, 1'b0);

        repeat (2) @(posedge csi_clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
